// File: rtl/alarm_annunciator.sv
// alarm_annunciator
//   Sequential annunciator for the board's raw alarm conditions. Each channel
//   runs its own acknowledge state machine. The machine drives a blinking or
//   steady lamp, a shared buzzer, and a first-out indicator.
//
//   Ports
//     clk_2        system clock, rising edge
//     reset        asynchronous, active-high reset
//     alarm_req    raw alarm conditions (async), 1 = condition present
//     ack          acknowledge switch (async level); only its rising edge acts
//     led          per-channel lamp: off / fast blink / steady / slow blink
//     buzzer       1 while any channel is unacknowledged
//     any_alarm    1 while any channel is not NORMAL
//     first_valid  first_idx holds a valid first-out channel
//     first_idx    lowest channel that tripped first since all were NORMAL
//
//   state      | meaning
//   -----------+----------------------------------------------------------
//   NORMAL     | no condition, nothing pending
//   UNACK      | condition present, not yet acknowledged (fast blink)
//   ACKED      | condition present, acknowledged (steady on)
//   RTN_UNACK  | condition cleared before acknowledge (slow blink)
module alarm_annunciator #(
    parameter int NCH       = 4,
    parameter int FAST_HALF = 4
) (
    input  logic                   clk_2,
    input  logic                   reset,
    input  logic [NCH-1:0]         alarm_req,
    input  logic                   ack,
    output logic [NCH-1:0]         led,
    output logic                   buzzer,
    output logic                   any_alarm,
    output logic                   first_valid,
    output logic [$clog2(NCH)-1:0] first_idx
);

    localparam int IDX_W = $clog2(NCH);
    localparam int CNT_N = 8 * FAST_HALF;
    localparam int CNT_W = $clog2(CNT_N);

    localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(CNT_N - 1);
    localparam logic [CNT_W-1:0] FAST_H  = CNT_W'(FAST_HALF);
    localparam logic [CNT_W-1:0] FAST_P  = CNT_W'(2 * FAST_HALF);
    localparam logic [CNT_W-1:0] SLOW_H  = CNT_W'(4 * FAST_HALF);

    typedef enum logic [1:0] {
        ST_NORMAL    = 2'd0,
        ST_UNACK     = 2'd1,
        ST_ACKED     = 2'd2,
        ST_RTN_UNACK = 2'd3
    } state_t;

    logic [NCH-1:0]   req_s1_q;
    logic [NCH-1:0]   req_s_q;
    logic             ack_s1_q;
    logic             ack_s_q;
    logic             ack_s_d_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    state_t           state_q [NCH];
    state_t           state_d [NCH];
    logic             first_valid_q;
    logic             first_valid_d;
    logic [IDX_W-1:0] first_idx_q;
    logic [IDX_W-1:0] first_idx_d;

    logic             ack_pulse;
    logic             fast;
    logic             slow;
    logic             all_cur_normal;
    logic             all_next_normal;
    logic             trip_found;
    logic [IDX_W-1:0] trip_idx;

    assign ack_pulse = ack_s_q & ~ack_s_d_q;
    assign fast      = (cnt_q % FAST_P) < FAST_H;
    assign slow      = cnt_q < SLOW_H;

    always_comb begin
        cnt_d = (cnt_q == CNT_TOP) ? '0 : cnt_q + 1'b1;
    end

    // Per-channel next state. The acknowledge pulse is shared by all channels.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            state_d[i] = state_q[i];
            unique case (state_q[i])
                ST_NORMAL: begin
                    if (req_s_q[i]) state_d[i] = ST_UNACK;
                end
                ST_UNACK: begin
                    if (ack_pulse)     state_d[i] = req_s_q[i] ? ST_ACKED : ST_NORMAL;
                    else if (!req_s_q[i]) state_d[i] = ST_RTN_UNACK;
                end
                ST_ACKED: begin
                    if (!req_s_q[i]) state_d[i] = ST_NORMAL;
                end
                ST_RTN_UNACK: begin
                    // A re-trip beats a same-cycle ack, so it needs a fresh ack.
                    if (req_s_q[i])    state_d[i] = ST_UNACK;
                    else if (ack_pulse) state_d[i] = ST_NORMAL;
                end
                default: state_d[i] = ST_NORMAL;
            endcase
        end
    end

    // First-out capture. The scan runs from the top index down, so the lowest
    // tripping channel wins when several trip in the same cycle.
    always_comb begin
        all_cur_normal  = 1'b1;
        all_next_normal = 1'b1;
        trip_found      = 1'b0;
        trip_idx        = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (state_q[i] != ST_NORMAL) all_cur_normal = 1'b0;
            if (state_d[i] != ST_NORMAL) all_next_normal = 1'b0;
            if (state_q[i] == ST_NORMAL && state_d[i] == ST_UNACK) begin
                trip_found = 1'b1;
                trip_idx   = IDX_W'(i);
            end
        end

        first_valid_d = first_valid_q;
        first_idx_d   = first_idx_q;
        if (all_next_normal) begin
            first_valid_d = 1'b0;
            first_idx_d   = '0;
        end else if (all_cur_normal && trip_found) begin
            first_valid_d = 1'b1;
            first_idx_d   = trip_idx;
        end
    end

    always_comb begin
        led       = '0;
        buzzer    = 1'b0;
        any_alarm = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            unique case (state_q[i])
                ST_NORMAL:    led[i] = 1'b0;
                ST_UNACK:     led[i] = fast;
                ST_ACKED:     led[i] = 1'b1;
                ST_RTN_UNACK: led[i] = slow;
                default:      led[i] = 1'b0;
            endcase
            if (state_q[i] == ST_UNACK || state_q[i] == ST_RTN_UNACK) buzzer = 1'b1;
            if (state_q[i] != ST_NORMAL) any_alarm = 1'b1;
        end
    end

    assign first_valid = first_valid_q;
    assign first_idx   = first_idx_q;

    always_ff @(posedge clk_2 or posedge reset) begin
        if (reset) begin
            req_s1_q      <= '0;
            req_s_q       <= '0;
            ack_s1_q      <= 1'b0;
            ack_s_q       <= 1'b0;
            ack_s_d_q     <= 1'b0;
            cnt_q         <= '0;
            first_valid_q <= 1'b0;
            first_idx_q   <= '0;
            for (int i = 0; i < NCH; i++) state_q[i] <= ST_NORMAL;
        end else begin
            req_s1_q      <= alarm_req;
            req_s_q       <= req_s1_q;
            ack_s1_q      <= ack;
            ack_s_q       <= ack_s1_q;
            ack_s_d_q     <= ack_s_q;
            cnt_q         <= cnt_d;
            first_valid_q <= first_valid_d;
            first_idx_q   <= first_idx_d;
            for (int i = 0; i < NCH; i++) state_q[i] <= state_d[i];
        end
    end

endmodule

// File: tb/tb_alarm_annunciator.sv
// tb_alarm_annunciator
//   Directed bench for alarm_annunciator with NCH=4, FAST_HALF=2. The blink
//   counter runs 0..15: fast blink is on while (cnt % 4) < 2, and slow blink
//   is on while cnt < 8. An input driven just after edge e takes effect in
//   the state at edge e+3 (edge e+1 samples it, edge e+2 syncs it, edge e+3
//   updates the state).
module tb_alarm_annunciator;

    logic       clk_2 = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] alarm_req = 4'b0000;
    logic       ack = 1'b0;
    logic [3:0] led;
    logic       buzzer;
    logic       any_alarm;
    logic       first_valid;
    logic [1:0] first_idx;

    int checks   = 0;
    int failures = 0;

    logic [3:0] m_cnt;
    logic [3:0] exp_led;

    alarm_annunciator #(.NCH(4), .FAST_HALF(2)) dut (
        .clk_2      (clk_2),
        .reset      (reset),
        .alarm_req  (alarm_req),
        .ack        (ack),
        .led        (led),
        .buzzer     (buzzer),
        .any_alarm  (any_alarm),
        .first_valid(first_valid),
        .first_idx  (first_idx)
    );

    always #5 clk_2 = ~clk_2;

    // Reference blink phase: cleared by reset, advances once per edge, and
    // wraps after 16 counts.
    always @(posedge clk_2 or posedge reset) begin
        if (reset) m_cnt <= 4'd0;
        else       m_cnt <= m_cnt + 4'd1;
    end

    function automatic logic fast_b();
        return (int'(m_cnt) % 4) < 2;
    endfunction

    function automatic logic slow_b();
        return int'(m_cnt) < 8;
    endfunction

    task automatic tick();
        @(posedge clk_2);
        #1;
    endtask

    task automatic pulse_ack();
        ack = 1'b1;
        tick();
        ack = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        checks++;
        if (led !== 4'b0000) begin failures++; $display("FAIL reset_led got=%b exp=0000", led); end
        checks++;
        if (buzzer !== 1'b0 || any_alarm !== 1'b0) begin
            failures++; $display("FAIL reset_flags buzzer=%b any_alarm=%b exp=0/0", buzzer, any_alarm);
        end
        checks++;
        if (first_valid !== 1'b0 || first_idx !== 2'd0) begin
            failures++; $display("FAIL reset_first valid=%b idx=%0d exp=0/0", first_valid, first_idx);
        end
        @(negedge clk_2);
        reset = 1'b0;
    endtask

    task automatic test_basic();
        alarm_req = 4'b0100;
        tick(); tick();
        checks++;
        if (any_alarm !== 1'b0) begin failures++; $display("FAIL basic_latency any_alarm=%b exp=0", any_alarm); end
        tick();
        checks++;
        if (buzzer !== 1'b1 || any_alarm !== 1'b1) begin
            failures++; $display("FAIL basic_trip buzzer=%b any_alarm=%b exp=1/1", buzzer, any_alarm);
        end
        checks++;
        if (first_valid !== 1'b1 || first_idx !== 2'd2) begin
            failures++; $display("FAIL basic_first valid=%b idx=%0d exp=1/2", first_valid, first_idx);
        end
        for (int i = 0; i < 8; i++) begin
            exp_led = {1'b0, fast_b(), 2'b00};
            checks++;
            if (led !== exp_led) begin
                failures++; $display("FAIL basic_fast_blink cyc=%0d led=%b exp=%b", i, led, exp_led);
            end
            tick();
        end
        pulse_ack();
        tick(); tick();
        checks++;
        if (led !== 4'b0100 || buzzer !== 1'b0 || any_alarm !== 1'b1) begin
            failures++; $display("FAIL basic_acked led=%b buzzer=%b any=%b exp=0100/0/1", led, buzzer, any_alarm);
        end
        alarm_req = 4'b0000;
        repeat (3) tick();
        checks++;
        if (led !== 4'b0000 || any_alarm !== 1'b0 || first_valid !== 1'b0) begin
            failures++; $display("FAIL basic_clear led=%b any=%b fv=%b exp=0000/0/0", led, any_alarm, first_valid);
        end
    endtask

    task automatic test_return_before_ack();
        alarm_req = 4'b0010;
        repeat (5) tick();
        alarm_req = 4'b0000;
        repeat (3) tick();
        for (int i = 0; i < 16; i++) begin
            exp_led = {2'b00, slow_b(), 1'b0};
            checks++;
            if (led !== exp_led || buzzer !== 1'b1) begin
                failures++; $display("FAIL rtn_slow_blink cyc=%0d led=%b buzzer=%b exp=%b/1", i, led, buzzer, exp_led);
            end
            tick();
        end
        checks++;
        if (first_valid !== 1'b1 || first_idx !== 2'd1) begin
            failures++; $display("FAIL rtn_first valid=%b idx=%0d exp=1/1", first_valid, first_idx);
        end
        pulse_ack();
        tick(); tick();
        checks++;
        if (led !== 4'b0000 || buzzer !== 1'b0 || first_valid !== 1'b0 || any_alarm !== 1'b0) begin
            failures++; $display("FAIL rtn_ack led=%b buzzer=%b fv=%b any=%b exp=0000/0/0/0",
                                 led, buzzer, first_valid, any_alarm);
        end
    endtask

    task automatic test_simultaneous();
        alarm_req = 4'b1010;
        repeat (3) tick();
        checks++;
        if (first_valid !== 1'b1 || first_idx !== 2'd1) begin
            failures++; $display("FAIL simul_first valid=%b idx=%0d exp=1/1", first_valid, first_idx);
        end
        alarm_req = 4'b1011;
        repeat (3) tick();
        exp_led = {fast_b(), 1'b0, fast_b(), fast_b()};
        checks++;
        if (led !== exp_led) begin failures++; $display("FAIL simul_led led=%b exp=%b", led, exp_led); end
        checks++;
        if (first_idx !== 2'd1 || first_valid !== 1'b1) begin
            failures++; $display("FAIL simul_hold valid=%b idx=%0d exp=1/1", first_valid, first_idx);
        end
        alarm_req = 4'b0000;
        repeat (3) tick();
        checks++;
        if (buzzer !== 1'b1 || first_valid !== 1'b1) begin
            failures++; $display("FAIL simul_rtn buzzer=%b fv=%b exp=1/1", buzzer, first_valid);
        end
        pulse_ack();
        tick(); tick();
        checks++;
        if (first_valid !== 1'b0 || any_alarm !== 1'b0 || first_idx !== 2'd0) begin
            failures++; $display("FAIL simul_clear fv=%b any=%b idx=%0d exp=0/0/0", first_valid, any_alarm, first_idx);
        end
    endtask

    task automatic test_held_ack();
        ack = 1'b1;
        repeat (10) tick();
        alarm_req = 4'b0001;
        repeat (3) tick();
        for (int i = 0; i < 7; i++) begin
            exp_led = {3'b000, fast_b()};
            checks++;
            if (led !== exp_led || buzzer !== 1'b1) begin
                failures++; $display("FAIL held_unack cyc=%0d led=%b buzzer=%b exp=%b/1", i, led, buzzer, exp_led);
            end
            tick();
        end
        ack = 1'b0;
        repeat (3) tick();
        checks++;
        if (buzzer !== 1'b1) begin failures++; $display("FAIL held_release buzzer=%b exp=1", buzzer); end
        ack = 1'b1;
        tick(); tick();
        checks++;
        if (buzzer !== 1'b1) begin failures++; $display("FAIL held_relatch buzzer=%b exp=1", buzzer); end
        tick();
        checks++;
        if (led !== 4'b0001 || buzzer !== 1'b0) begin
            failures++; $display("FAIL held_acked led=%b buzzer=%b exp=0001/0", led, buzzer);
        end
        ack = 1'b0;
        alarm_req = 4'b0000;
        repeat (3) tick();
        checks++;
        if (any_alarm !== 1'b0 || first_valid !== 1'b0) begin
            failures++; $display("FAIL held_clear any=%b fv=%b exp=0/0", any_alarm, first_valid);
        end
    endtask

    task automatic test_retrip();
        alarm_req = 4'b1000;
        repeat (3) tick();
        alarm_req = 4'b0000;
        repeat (3) tick();
        exp_led = {slow_b(), 3'b000};
        checks++;
        if (led !== exp_led || buzzer !== 1'b1) begin
            failures++; $display("FAIL retrip_rtn led=%b buzzer=%b exp=%b/1", led, buzzer, exp_led);
        end
        alarm_req = 4'b1000;
        pulse_ack();
        tick(); tick();
        for (int i = 0; i < 4; i++) begin
            exp_led = {fast_b(), 3'b000};
            checks++;
            if (led !== exp_led || buzzer !== 1'b1) begin
                failures++; $display("FAIL retrip_unack cyc=%0d led=%b buzzer=%b exp=%b/1", i, led, buzzer, exp_led);
            end
            tick();
        end
        checks++;
        if (first_valid !== 1'b1 || first_idx !== 2'd3) begin
            failures++; $display("FAIL retrip_first valid=%b idx=%0d exp=1/3", first_valid, first_idx);
        end
        pulse_ack();
        tick(); tick();
        checks++;
        if (led !== 4'b1000 || buzzer !== 1'b0) begin
            failures++; $display("FAIL retrip_acked led=%b buzzer=%b exp=1000/0", led, buzzer);
        end
        alarm_req = 4'b0000;
        repeat (3) tick();
    endtask

    task automatic test_reset_mid();
        alarm_req = 4'b0001;
        repeat (3) tick();
        pulse_ack();
        tick(); tick();
        alarm_req = 4'b0101;
        repeat (3) tick();
        exp_led = {1'b0, fast_b(), 1'b0, 1'b1};
        checks++;
        if (led !== exp_led || buzzer !== 1'b1 || first_idx !== 2'd0 || first_valid !== 1'b1) begin
            failures++; $display("FAIL mid_setup led=%b buzzer=%b fv=%b idx=%0d exp=%b/1/1/0",
                                 led, buzzer, first_valid, first_idx, exp_led);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (led !== 4'b0000 || buzzer !== 1'b0 || first_valid !== 1'b0 || any_alarm !== 1'b0) begin
            failures++; $display("FAIL mid_async_reset led=%b buzzer=%b fv=%b any=%b exp=0000/0/0/0",
                                 led, buzzer, first_valid, any_alarm);
        end
        @(negedge clk_2);
        @(negedge clk_2);
        reset = 1'b0;
        tick(); tick();
        checks++;
        if (any_alarm !== 1'b0) begin failures++; $display("FAIL mid_resync any=%b exp=0", any_alarm); end
        tick();
        exp_led = {1'b0, fast_b(), 1'b0, fast_b()};
        checks++;
        if (led !== exp_led || buzzer !== 1'b1) begin
            failures++; $display("FAIL mid_retrip led=%b buzzer=%b exp=%b/1", led, buzzer, exp_led);
        end
        checks++;
        if (first_valid !== 1'b1 || first_idx !== 2'd0) begin
            failures++; $display("FAIL mid_first valid=%b idx=%0d exp=1/0", first_valid, first_idx);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_return_before_ack();
        test_simultaneous();
        test_held_ack();
        test_retrip();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alarm_annunciator.md
Name: alarm_annunciator

Overview:
- Sequential counterpart to the board's combinational alarm conditions (vault door, end-of-shift, greenhouse temperature).
- Takes NCH raw alarm-request lines and a shared acknowledge switch, and runs a per-channel annunciation state machine.
- Drives blinking or steady LEDs, a buzzer, and a first-out indicator.
- Sits between the condition logic in top (alarm_req) and the LED/SEG outputs.

Parameters:
- NCH, 4, number of alarm channels (2..8).
- FAST_HALF, 4, fast-blink half-period in clk_2 cycles (≥1); slow-blink half-period is 4*FAST_HALF.

Ports:
- clk_2  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- alarm_req  input  NCH  raw alarm conditions, asynchronous to clk_2; 1 = condition present.
- ack  input  1  acknowledge switch, asynchronous; level input, acted on at rising edge only.
- led  output  NCH  per-channel annunciator lamp.
- buzzer  output  1  1 while any channel is unacknowledged.
- any_alarm  output  1  1 while any channel is not NORMAL.
- first_valid  output  1  first-out index is valid.
- first_idx  output  $clog2(NCH)  lowest channel that tripped first since all channels were NORMAL.

Behaviour:
- Clock and reset: one clock (clk_2); reset is asynchronous and active-high.
- Reset values: all channel states NORMAL, synchronizers 0, blink counter 0, first_valid 0, first_idx 0. Therefore led=0, buzzer=0, any_alarm=0.
- Reset mid-operation returns to these values immediately, regardless of blink phase or state.
- Synchronization:
  - alarm_req and ack each pass through a 2-flop synchronizer (req_s, ack_s).
  - ack_pulse = ack_s & ~ack_s_d (a third flop), giving one cycle per rising edge of ack.
  - An input change sampled at edge k updates the state at edge k+2.
- Blink counter: cnt is free-running 0..8*FAST_HALF-1, then wraps to 0.
  - fast = ((cnt mod 2*FAST_HALF) < FAST_HALF).
  - slow = (cnt < 4*FAST_HALF).
  - Blink phase at trip is not aligned to the alarm.
- Per-channel FSM (state registered, r = req_s[i], a = ack_pulse; ack is global to all channels):
  - NORMAL: r=1 -> UNACK; else stay.
  - UNACK: a=1 -> ACKED if r=1, NORMAL if r=0; else r=0 -> RTN_UNACK; else stay.
  - ACKED: r=0 -> NORMAL; a is ignored.
  - RTN_UNACK: r=1 -> UNACK, with priority over a same-cycle ack (a re-trip needs a fresh ack); else a=1 -> NORMAL; else stay.
- Outputs (combinational from registered state and cnt):
  - led[i]: NORMAL 0, UNACK fast, ACKED 1, RTN_UNACK slow.
  - buzzer = any channel in UNACK or RTN_UNACK.
  - any_alarm = any channel not NORMAL.
- First-out:
  - If the next state of every channel is NORMAL: first_valid<=0, first_idx<=0.
  - Else if all current states are NORMAL and at least one channel goes to UNACK: first_valid<=1, first_idx<=lowest tripping index.
  - Otherwise hold. Later trips never overwrite a valid first_idx.
- Holding ack high produces exactly one pulse. Channels tripping while ack is held stay UNACK until ack falls and rises again.

Test Plan (NCH=4, FAST_HALF=2):
- Basic flow:
  - Set alarm_req=4'b0100 -> after 2 edges led[2] toggles every 2 cycles, buzzer=1, any_alarm=1, first_valid=1, first_idx=2.
  - Pulse ack -> led[2]=1 steady, buzzer=0.
  - Drop req -> led=0, any_alarm=0, first_valid=0.
- Return before ack:
  - Hold alarm_req[1]=1 for 5 cycles, then release -> led[1] blinks with 8-cycle half-period, buzzer stays 1.
  - Pulse ack -> led[1]=0, buzzer=0, first_valid=0.
- Simultaneous trip: alarm_req=4'b1010 in one cycle -> first_idx=1. Later set bit 0 -> first_idx stays 1. Clear all and ack -> first_valid=0.
- Held ack:
  - Hold ack=1 for 20 cycles; trip ch0 at cycle 10 -> ch0 stays UNACK (fast blink, buzzer=1).
  - Release ack, then raise it again -> ch0 becomes ACKED.
- Re-trip priority: put ch3 in RTN_UNACK, then re-raise req[3] with the ack rising edge in the same cycle -> ch3 in UNACK (fast blink), buzzer=1.
- Reset mid-operation: with ch0 ACKED and ch2 UNACK, assert reset asynchronously between edges -> led=0, buzzer=0, first_valid=0 immediately. After release with req still high -> both channels re-trip to UNACK after 2 edges, first_idx=0.
